// File: rtl/bram_arbiter.sv
// bram_arbiter: three-requester BRAM arbiter (cpu/dma round-robin, aging prefetch)
// with a one-cycle issue stage and an in-order read tag FIFO for return routing.
module bram_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int PF_AGE    = 16,
    parameter int TAG_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              pf_req,
    input  logic              pf_wr,
    input  logic [ADDR_W-1:0] pf_addr,
    input  logic [DATA_W-1:0] pf_wdata,
    output logic              cpu_gnt,
    output logic              dma_gnt,
    output logic              pf_gnt,
    output logic              cpu_rvalid,
    output logic              dma_rvalid,
    output logic              pf_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              bram_in_valid,
    output logic              bram_wr,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_di,
    output logic              bram_sel,
    input  logic              bram_rvalid,
    input  logic [DATA_W-1:0] bram_do,
    output logic              err_orphan
);
    localparam int TW    = $clog2(TAG_DEPTH);
    localparam int CW    = $clog2(TAG_DEPTH + 1);
    localparam int AGE_W = $clog2(PF_AGE + 1);

    typedef enum logic [1:0] {ID_CPU, ID_DMA, ID_PF} id_t;

    logic              last_grant;
    logic [AGE_W-1:0]  pf_age;
    id_t               tags [TAG_DEPTH];
    logic [TW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              pop, push, can_read, any_gnt;
    logic              cpu_ok, dma_ok, pf_ok, pf_prom;
    logic              g_wr;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    id_t               g_id, head;

    // a pop in the same cycle frees a slot, so a read may push even at full
    assign pop      = bram_rvalid && count != '0;
    assign can_read = count != CW'(TAG_DEPTH) || pop;
    assign cpu_ok   = cpu_req && (cpu_wr || can_read);
    assign dma_ok   = dma_req && (dma_wr || can_read);
    assign pf_ok    = pf_req && (pf_wr || can_read);
    assign pf_prom  = pf_age >= AGE_W'(PF_AGE);

    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        pf_gnt  = 1'b0;
        if (rst_n) begin
            if (pf_ok && pf_prom)
                pf_gnt = 1'b1;
            else if (cpu_ok && (!dma_ok || !last_grant))
                cpu_gnt = 1'b1;
            else if (dma_ok)
                dma_gnt = 1'b1;
            else if (pf_ok)
                pf_gnt = 1'b1;
        end
    end

    assign any_gnt = cpu_gnt || dma_gnt || pf_gnt;
    assign g_wr    = cpu_gnt ? cpu_wr : dma_gnt ? dma_wr : pf_wr;
    assign g_addr  = cpu_gnt ? cpu_addr : dma_gnt ? dma_addr : pf_addr;
    assign g_data  = cpu_gnt ? cpu_wdata : dma_gnt ? dma_wdata : pf_wdata;
    assign g_id    = cpu_gnt ? ID_CPU : dma_gnt ? ID_DMA : ID_PF;
    assign push    = any_gnt && !g_wr;

    assign head       = tags[rd_ptr];
    assign cpu_rvalid = pop && head == ID_CPU;
    assign dma_rvalid = pop && head == ID_DMA;
    assign pf_rvalid  = pop && head == ID_PF;
    assign rdata      = bram_do;

    always_ff @(posedge clk) begin
        if (push)
            tags[wr_ptr] <= g_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant    <= 1'b0;
            pf_age        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_orphan    <= 1'b0;
            bram_in_valid <= 1'b0;
            bram_wr       <= 1'b0;
            bram_addr     <= '0;
            bram_di       <= '0;
            bram_sel      <= 1'b0;
        end else begin
            if (cpu_gnt || dma_gnt)
                last_grant <= cpu_gnt;
            if (!pf_req || pf_gnt)
                pf_age <= '0;
            else if (pf_age != '1)
                pf_age <= pf_age + 1'b1;
            if (push)
                wr_ptr <= (wr_ptr == TW'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == TW'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (bram_rvalid && count == '0)
                err_orphan <= 1'b1;
            bram_in_valid <= any_gnt;
            bram_sel      <= cpu_gnt;
            if (any_gnt) begin
                bram_wr   <= g_wr;
                bram_addr <= g_addr;
                bram_di   <= g_data;
            end
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed-vector bench for bram_arbiter with hand-computed expectations.
module tb_bram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_wr, dma_req, dma_wr, pf_req, pf_wr;
    logic [12:0] cpu_addr, dma_addr, pf_addr;
    logic [31:0] cpu_wdata, dma_wdata, pf_wdata;
    logic        cpu_gnt, dma_gnt, pf_gnt, cpu_rvalid, dma_rvalid, pf_rvalid;
    logic [31:0] rdata, bram_di, bram_do;
    logic        bram_in_valid, bram_wr, bram_sel, bram_rvalid, err_orphan;
    logic [12:0] bram_addr;
    int          n_chk = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    bram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .pf_req(pf_req), .pf_wr(pf_wr), .pf_addr(pf_addr), .pf_wdata(pf_wdata),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .pf_gnt(pf_gnt),
        .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid), .pf_rvalid(pf_rvalid),
        .rdata(rdata), .bram_in_valid(bram_in_valid), .bram_wr(bram_wr),
        .bram_addr(bram_addr), .bram_di(bram_di), .bram_sel(bram_sel),
        .bram_rvalid(bram_rvalid), .bram_do(bram_do), .err_orphan(err_orphan)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {cpu_req, cpu_wr, dma_req, dma_wr, pf_req, pf_wr, bram_rvalid} = '0;
        cpu_addr = 13'h010; dma_addr = 13'h020; pf_addr = 13'h030;
        cpu_wdata = 32'hC0; dma_wdata = 32'hD0; pf_wdata = 32'hE0;
        bram_do = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        cpu_req = 1'b1;
        #1;
        check("rst_gnt", {cpu_gnt, dma_gnt, pf_gnt}, 0);
        check("rst_rvalid", {cpu_rvalid, dma_rvalid, pf_rvalid}, 0);
        check("rst_bram", {bram_in_valid, bram_wr, bram_sel, err_orphan}, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_di", bram_di, 0);
        tick();

        // cpu/dma alternation; the very first cycle after reset release grants
        rst_n = 1'b1;
        cpu_req = 1'b1;
        dma_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr_cpu_gnt", cpu_gnt, (i % 2) == 0);
            check("rr_dma_gnt", dma_gnt, (i % 2) == 1);
            tick();
            check("rr_valid", bram_in_valid, 1);
            check("rr_sel", bram_sel, (i % 2) == 0);
            check("rr_addr", bram_addr, (i % 2) == 0 ? 32'h010 : 32'h020);
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        check("idle_valid", bram_in_valid, 0);

        // in-order return routing
        do_reset();
        cpu_req = 1'b1;
        #1 check("ord_cpu_gnt", cpu_gnt, 1);
        tick();
        cpu_req = 1'b0;
        dma_req = 1'b1;
        #1 check("ord_dma_gnt", dma_gnt, 1);
        tick();
        dma_req = 1'b0;
        pf_req = 1'b1;
        #1 check("ord_pf_gnt", pf_gnt, 1);
        tick();
        check("ord_pf_issue", {bram_in_valid, bram_sel, bram_wr}, 3'b100);
        check("ord_pf_addr", bram_addr, 32'h030);
        pf_req = 1'b0;
        bram_rvalid = 1'b1;
        bram_do = 32'hA;
        #1 check("ret0_vec", {cpu_rvalid, dma_rvalid, pf_rvalid}, 3'b100);
        check("ret0_data", rdata, 32'hA);
        tick();
        bram_do = 32'hB;
        #1 check("ret1_vec", {cpu_rvalid, dma_rvalid, pf_rvalid}, 3'b010);
        check("ret1_data", rdata, 32'hB);
        tick();
        bram_do = 32'hC;
        #1 check("ret2_vec", {cpu_rvalid, dma_rvalid, pf_rvalid}, 3'b001);
        check("ret2_data", rdata, 32'hC);
        tick();
        bram_rvalid = 1'b0;
        #1 check("orph_before", err_orphan, 0);

        // orphan return on empty FIFO
        bram_rvalid = 1'b1;
        #1 check("orph_vec", {cpu_rvalid, dma_rvalid, pf_rvalid}, 0);
        tick();
        bram_rvalid = 1'b0;
        check("orph_set", err_orphan, 1);
        tick();
        tick();
        check("orph_hold", err_orphan, 1);
        rst_n = 1'b0;
        #1 check("orph_clear", err_orphan, 0);
        do_reset();

        // tag FIFO full: reads stall, writes pass, pop frees a slot the same cycle
        cpu_req = 1'b1;
        w = 0;
        for (int i = 0; i < 16; i++) begin
            #1 w += cpu_gnt;
            tick();
        end
        check("full_16_reads", w, 16);
        #1 check("full_17th_read", cpu_gnt, 0);
        cpu_wr = 1'b1;
        cpu_wdata = 32'h55;
        #1 check("full_write_gnt", cpu_gnt, 1);
        tick();
        check("full_write_issue", {bram_in_valid, bram_wr}, 2'b11);
        check("full_write_di", bram_di, 32'h55);
        cpu_wr = 1'b0;
        bram_rvalid = 1'b1;
        bram_do = 32'h77;
        #1 check("full_pop_gnt", cpu_gnt, 1);
        check("full_pop_rvalid", cpu_rvalid, 1);
        tick();
        bram_rvalid = 1'b0;
        #1 check("full_still_full", cpu_gnt, 0);

        // prefetch aging under a saturating cpu
        do_reset();
        cpu_req = 1'b1;
        cpu_wr = 1'b1;
        pf_req = 1'b1;
        w = 0;
        #1;
        while (!pf_gnt && w < 40) begin
            tick();
            w++;
            #1;
        end
        check("pf_wait_cycles", w, 16);
        check("pf_promote_gnt", {cpu_gnt, pf_gnt}, 2'b01);
        tick();
        check("pf_issue", {bram_in_valid, bram_sel, bram_wr}, 3'b100);
        check("pf_age_clear", dut.pf_age, 0);
        #1 check("pf_after_gnt", {cpu_gnt, pf_gnt}, 2'b10);

        // reset with 5 tags outstanding
        do_reset();
        cpu_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1 check("mid_rst_gnt", {cpu_gnt, dma_gnt, pf_gnt}, 0);
        check("mid_rst_bram", {bram_in_valid, bram_wr, bram_sel, err_orphan}, 0);
        check("mid_rst_addr", bram_addr, 0);
        tick();
        cpu_req = 1'b0;
        rst_n = 1'b1;
        bram_rvalid = 1'b1;
        #1 check("post_rst_vec", {cpu_rvalid, dma_rvalid, pf_rvalid}, 0);
        tick();
        #1 check("post_rst_vec2", {cpu_rvalid, dma_rvalid, pf_rvalid}, 0);
        check("post_rst_orphan", err_orphan, 1);
        tick();
        bram_rvalid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
- REQ-001: The block SHALL have the parameter ADDR_W, default 13, meaning the BRAM word address width.
- REQ-002: The block SHALL have the parameter DATA_W, default 32, meaning the data width.
- REQ-003: The block SHALL have the parameter PF_AGE, default 16, meaning the wait cycles after which a pending prefetch request is promoted.
- REQ-004: The block SHALL have the parameter TAG_DEPTH, default 16, meaning the maximum reads in flight across all requesters.
- REQ-005: The block SHALL provide the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-006: The block SHALL provide the port rst_n, input, 1 bit: asynchronous, active-low reset.
- REQ-007: The block SHALL provide, for each requester X in {cpu, dma, pf}, the inputs X_req (1), X_wr (1, 1 = write), X_addr (ADDR_W) and X_wdata (DATA_W).
- REQ-008: The block SHALL provide, for each X, the output X_gnt, 1 bit: the request is accepted this cycle.
- REQ-009: The block SHALL provide, for each X, the output X_rvalid, 1 bit: read data for X is on rdata.
- REQ-010: The block SHALL provide the output rdata, DATA_W: equal to bram_do.
- REQ-011: The block SHALL provide the outputs bram_in_valid (1), bram_wr (1), bram_addr (ADDR_W), bram_di (DATA_W) and bram_sel (1, 1 = cpu), all driven to the BRAM controller.
- REQ-012: The block SHALL provide the inputs bram_rvalid (1, any read-data-valid from the controller) and bram_do (DATA_W).
- REQ-013: The block SHALL provide the output err_orphan, 1 bit: sticky flag set when read data arrives with no tag outstanding.

Function
- REQ-014: The block SHALL grant at most one X_gnt per cycle, combinationally from the current X_req and registered state.
- REQ-015: A requester SHALL be eligible when X_req=1 and, if X_wr=0, the tag FIFO is not full; writes are eligible regardless of tag FIFO occupancy.
- REQ-016: Priority SHALL be ordered as follows: a promoted pf first, then cpu/dma round-robin, then a non-promoted pf.
- REQ-017: Round-robin SHALL use a 1-bit last_grant register (reset 0 = dma); when both cpu and dma are eligible, the one not last granted wins, and last_grant updates only on a cpu or dma grant.
- REQ-018: pf_age SHALL be a saturating counter that increments each cycle pf_req=1 and pf_gnt=0, and clears on pf_gnt or pf_req=0.
- REQ-019: pf SHALL be promoted when pf_age >= PF_AGE.
- REQ-020: On a grant, the next cycle SHALL present bram_in_valid=1 with the granted wr, addr and wdata, and bram_sel=1 only for cpu; otherwise bram_in_valid=0.
- REQ-021: Issue latency SHALL be 1 cycle, and back-to-back grants SHALL give one issue every cycle.
- REQ-022: On a granted read, the requester ID SHALL be pushed to the TAG_DEPTH-entry in-order tag FIFO in the same cycle as the grant.
- REQ-023: On bram_rvalid=1 with the FIFO non-empty, the head SHALL be popped and the matching X_rvalid asserted combinationally in that cycle, with rdata=bram_do.
- REQ-024: Simultaneous push and pop SHALL both occur, leaving the count unchanged; a push is permitted at full only when a pop occurs in the same cycle.
- REQ-025: On bram_rvalid=1 with the FIFO empty, no X_rvalid SHALL assert and err_orphan SHALL set and hold until reset.
- REQ-026: Requester inputs are held by the requester until X_gnt; the block SHALL not latch an ungranted request.

Reset
- REQ-027: While rst_n=0, all of the following SHALL be 0: X_gnt, X_rvalid, bram_in_valid, bram_wr, bram_addr, bram_di, bram_sel, err_orphan, last_grant, pf_age, FIFO count and pointers.
- REQ-028: Reset asserted mid-operation SHALL discard all in-flight tags, and no X_rvalid SHALL assert for reads issued before reset.
- REQ-029: The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
- REQ-030: cpu and dma both request reads continuously -> grants alternate cpu, dma, cpu..., and bram_sel toggles 1,0,1 one cycle after each grant.
- REQ-031: pf_req held with cpu saturating -> pf_gnt asserts in cycle PF_AGE (16) of waiting, and pf_age returns to 0.
- REQ-032: 16 reads issued with no bram_rvalid -> the 17th read is not granted and a write is still granted; one bram_rvalid -> the read is granted that cycle.
- REQ-033: Issue cpu, dma, pf reads, then 3 bram_rvalid pulses with bram_do=0xA,0xB,0xC -> cpu_rvalid with 0xA, dma_rvalid with 0xB, pf_rvalid with 0xC, in order.
- REQ-034: bram_rvalid with empty FIFO -> no X_rvalid and err_orphan=1 until rst_n=0.
- REQ-035: rst_n pulsed low with 5 tags outstanding -> all outputs 0; later bram_rvalid pulses set err_orphan and produce no X_rvalid.
